// File: rtl/shift_normalizer_seq.sv
// shift_normalizer_seq: multi-cycle left/right normalizer; define SHIFT_NORMALIZER_DUAL_STEP_EN for two-bit stepping
module shift_normalizer_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic             choice,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] amt,
  output logic             zero
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] work;
  logic [CNT_W-1:0] cnt;
  logic dir;
  logic tgt;
  logic [WIDTH-1:0] step1;
  assign ready = (state == IDLE);
  assign tgt = dir ? work[0] : work[WIDTH-1];
  assign step1 = dir ? work >> 1 : work << 1;
`ifdef SHIFT_NORMALIZER_DUAL_STEP_EN
  logic adj;
  logic [WIDTH-1:0] step2;
  assign adj = dir ? work[1] : work[WIDTH-2];
  assign step2 = dir ? work >> 2 : work << 2;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      work <= '0;
      dir <= 1'b0;
      cnt <= '0;
      done <= 1'b0;
      y <= '0;
      amt <= '0;
      zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          work <= a;
          dir <= choice;
          cnt <= '0;
          zero <= (a == '0);
          if (a == '0) begin
            y <= '0;
            amt <= '0;
            done <= 1'b1;
            state <= DONE;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: if (tgt) begin
          y <= work;
          amt <= cnt;
          done <= 1'b1;
          state <= DONE;
        end else begin
`ifdef SHIFT_NORMALIZER_DUAL_STEP_EN
          work <= adj ? step1 : step2;
          cnt <= cnt + (adj ? CNT_W'(1) : CNT_W'(2));
`else
          work <= step1;
          cnt <= cnt + CNT_W'(1);
`endif
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_normalizer_seq.sv
// tb_shift_normalizer_seq: directed table and corner sequences for shift_normalizer_seq
module tb_shift_normalizer_seq;
  logic clk = 1'b0;
  logic reset, start, choice;
  logic [7:0] a;
  logic ready, done, zero;
  logic [7:0] y;
  logic [2:0] amt;
  int total = 0;
  int bad = 0;

  shift_normalizer_seq #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .choice(choice),
    .ready(ready), .done(done), .y(y), .amt(amt), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic       ch;
    logic [7:0] y;
    int         k;
    logic       z;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input int k, input logic z);
`ifdef SHIFT_NORMALIZER_DUAL_STEP_EN
    return z ? 1 : 2 + (k + 1) / 2;
`else
    return z ? 1 : 2 + k;
`endif
  endfunction

  // latency counts negedges after the accept edge until done is seen; 0 means timeout
  task automatic run(input logic [7:0] av, input logic ch, output int lat);
    @(negedge clk);
    a = av; choice = ch; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = ~av; choice = ~ch;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (done) lat = i;
    end
  endtask

  initial begin
    vec_t v[10];
    int lat, seen;
    v[0] = '{8'h16, 1'b0, 8'hB0, 3, 1'b0};
    v[1] = '{8'h16, 1'b1, 8'h0B, 1, 1'b0};
    v[2] = '{8'h01, 1'b0, 8'h80, 7, 1'b0};
    v[3] = '{8'h80, 1'b0, 8'h80, 0, 1'b0};
    v[4] = '{8'h00, 1'b0, 8'h00, 0, 1'b1};
    v[5] = '{8'h00, 1'b1, 8'h00, 0, 1'b1};
    v[6] = '{8'h01, 1'b1, 8'h01, 0, 1'b0};
    v[7] = '{8'h80, 1'b1, 8'h01, 7, 1'b0};
    v[8] = '{8'h0C, 1'b1, 8'h03, 2, 1'b0};
    v[9] = '{8'h30, 1'b0, 8'hC0, 2, 1'b0};
    reset = 1'b1; start = 1'b0; a = '0; choice = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_amt", int'(amt), 0);
    chk("rst_zero", int'(zero), 0);
    for (int i = 0; i < 10; i++) begin
      run(v[i].a, v[i].ch, lat);
      chk($sformatf("lat[%0d]", i), lat, exp_lat(v[i].k, v[i].z));
      chk($sformatf("y[%0d]", i), int'(y), int'(v[i].y));
      chk($sformatf("amt[%0d]", i), int'(amt), v[i].k);
      chk($sformatf("zero[%0d]", i), int'(zero), int'(v[i].z));
      @(negedge clk);
      chk($sformatf("pulse[%0d]", i), int'(done), 0);
      chk($sformatf("idle[%0d]", i), int'(ready), 1);
      chk($sformatf("hold_y[%0d]", i), int'(y), int'(v[i].y));
    end
    // a start raised while busy must be dropped, not queued
    @(negedge clk);
    a = 8'h01; choice = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_ready", int'(ready), 0);
    a = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int i = 4; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (done) lat = i;
    end
    chk("ign_lat", lat, exp_lat(7, 1'b0));
    chk("ign_y", int'(y), 8'h80);
    chk("ign_amt", int'(amt), 7);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("ign_no_second", seen, 0);
    // reset mid-operation aborts without a done pulse and clears outputs
    @(negedge clk);
    a = 8'h01; choice = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", int'(ready), 1);
    chk("abort_y", int'(y), 0);
    chk("abort_amt", int'(amt), 0);
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_normalizer_seq.md
Name: shift_normalizer_seq

Overview:
- Multi-cycle inverse of the datapath barrel shifter. It takes an 8-bit word and shifts it one bit per clock until a set bit reaches the target end, then reports the normalized word and the shift amount it applied.
- `choice`=0: left-normalize, so the leading one ends at the MSB.
- `choice`=1: right-normalize, so the trailing one ends at the LSB.
- Feeds the `amt`/`choice` inputs of the shifter path; a round trip through the shifter restores the original word.

Parameters:
- WIDTH, 8, data width in bits.
- CNT_W, 3, width of the shift-count output; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- a  input  WIDTH  word to normalize; captured on an accepted start.
- choice  input  1  direction; 0=left/MSB, 1=right/LSB; captured with `a`.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse when the result is valid.
- y  output  WIDTH  normalized word.
- amt  output  CNT_W  number of bit positions shifted.
- zero  output  1  captured word was all zeros.

Behaviour:
- Reset: state=IDLE, ready=1, done=0, y=0, amt=0, zero=0. Reset asserted mid-operation aborts the operation and clears the captured word, direction and count; no done pulse is issued.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - On start=1: capture `a` into a working register, capture `choice`, clear the count.
  - If a==0: set zero=1 and go to DONE.
  - Otherwise: set zero=0 and go to SHIFT.
- SHIFT:
  - ready=0. Each cycle, test the target bit: bit WIDTH-1 when choice=0, bit 0 when choice=1.
  - Target bit set: go to DONE.
  - Target bit clear: shift the working register 1 toward the target end, zero-fill the vacated bit, increment the count, stay in SHIFT.
  - A nonzero word guarantees termination after at most WIDTH-1 shifts. The count never wraps.
- DONE:
  - done=1 for exactly one cycle; y and amt are loaded from the working register and count on entry to this state.
  - Next state is IDLE unconditionally.
- Output hold: y, amt and zero hold their values from the last DONE until the next accepted start; they are not cleared when returning to IDLE.
- start while ready=0: ignored; it is not queued.
- start held high continuously: a new operation is accepted on the first IDLE cycle after each DONE. Back-to-back throughput is 1 idle cycle + latency.
- Latency, counted from the start-accepting edge to the cycle with done=1:
  - zero input: 1 cycle.
  - nonzero input: 2 + k cycles, where k = number of shifts.
- Width rule: amt = k, with 0 ≤ k ≤ WIDTH-1. y equals the original word shifted by k, zero-filled, in the chosen direction.
- A change to `a` or `choice` after the accepted start has no effect on the running operation.

Optional Feature:
- Macro: SHIFT_NORMALIZER_DUAL_STEP_EN.
- When defined, in SHIFT:
  - Target bit and the bit adjacent to it both clear: shift by 2 and add 2 to the count in one cycle.
  - Only the target bit clear: shift by 1 and add 1.
  - Final y, amt and zero are identical to the undefined build.
  - Latency for a nonzero input becomes 2 + ceil(k/2).
- When undefined: single-bit stepping as specified above. No extra logic is generated.

Test Plan:
- a=8'h16, choice=0, pulse start → y=8'hB0, amt=3, zero=0.
  - done exactly 5 cycles after the accept edge.
  - With DUAL_STEP: done after 4 cycles.
- a=8'h16, choice=1 → y=8'h0B, amt=1, done after 3 cycles.
- a=8'h01, choice=0 → y=8'h80, amt=7, done after 9 cycles (DUAL_STEP: 6).
- a=8'h80, choice=0 → y=8'h80, amt=0, done after 2 cycles.
- a=8'h00, either choice → zero=1, y=8'h00, amt=0, done after 1 cycle.
- a=8'h01, choice=0, then start=1 with a=8'hFF at cycle 3 → the second request is ignored.
  - First request completes with amt=7, y=8'h80.
- reset asserted at cycle 4 of the same case → ready=1, done never pulses, y=0, amt=0.
